// File: rtl/rv_core_pkg.sv
// -----------------------------------------------------------------------------
// rv_core_pkg
// Shared definitions for the multi-cycle RV32I core: the sequencer state
// encoding, the decoder's register-write-source and branch-mode codes, and the
// PC source select codes. The decoder and the sequencer both import this
// package so the two sides can never disagree on an encoding.
// -----------------------------------------------------------------------------
package rv_core_pkg;

   // Sequencer states. IDLE is the reset state and the only parking point.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_MEM    = 3'd4,
      ST_WB     = 3'd5,
      ST_TRAP   = 3'd6
   } state_t;

   // Register-file write source (decoder field dec_r_w_src).
   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_ALU  = 2'b01;
   localparam logic [1:0] RW_MEM  = 2'b10;
   localparam logic [1:0] RW_PC   = 2'b11;

   // Branch mode (decoder field dec_bra_mode).
   localparam logic [1:0] BRA_NONE = 2'b00;
   localparam logic [1:0] BRA_JMP  = 2'b01;
   localparam logic [1:0] BRA_CMP  = 2'b10;
   localparam logic [1:0] BRA_ALU  = 2'b11;

   // PC update source (sequencer output pc_src).
   localparam logic [1:0] PC_SRC_PC4 = 2'b00;
   localparam logic [1:0] PC_SRC_IMM = 2'b01;
   localparam logic [1:0] PC_SRC_ALU = 2'b10;

   // Next-PC source for a retiring instruction. A conditional branch only
   // takes the PC+imm path when the comparator says so.
   function automatic logic [1:0] pc_src_sel(input logic [1:0] bra_mode,
                                             input logic       cmp_taken);
      logic [1:0] sel;
      unique case (bra_mode)
         BRA_NONE: sel = PC_SRC_PC4;
         BRA_JMP:  sel = PC_SRC_IMM;
         BRA_CMP:  sel = cmp_taken ? PC_SRC_IMM : PC_SRC_PC4;
         BRA_ALU:  sel = PC_SRC_ALU;
         default:  sel = PC_SRC_PC4;
      endcase
      return sel;
   endfunction

endpackage : rv_core_pkg

// File: rtl/mem_watchdog.sv
// -----------------------------------------------------------------------------
// mem_watchdog
// Counts memory wait cycles for the sequencer and flags a timeout once the
// count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables the timeout.
//
// Ports
//   clk        in   core clock, rising edge
//   rst        in   synchronous, active-high reset
//   i_clear    in   1 = sequencer is entering a new state; restart the count
//   i_wait     in   1 = a memory request is outstanding and mem_ready=0
//   o_timeout  out  count has reached TIMEOUT_CYCLES (combinational from count)
//
// The timeout is a decode of the registered count, so it is seen in the cycle
// after the last counted wait. That cycle still samples mem_ready, which lets
// a late ready win over the timeout.
// -----------------------------------------------------------------------------
module mem_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_wait,
   output logic o_timeout
);

   localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] r_count;
   logic          w_at_limit;

   assign w_at_limit = (r_count == LIMIT);

   // The count saturates at the limit so it can never wrap back below it
   // while the sequencer is still deciding to trap.
   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_wait && !w_at_limit) begin
         r_count <= r_count + CW'(1);
      end
   end

   assign o_timeout = (TIMEOUT_CYCLES != 0) && w_at_limit;

endmodule : mem_watchdog

// File: rtl/multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// multicycle_sequencer
// Control FSM of the multi-cycle RV32I core. Walks every instruction through
// FETCH / DECODE / EXEC / [MEM] / WB, drives the single shared memory port,
// the IR load, the register-file write and the PC update, counts retired
// instructions and traps on illegal opcodes or memory timeouts.
//
// Parameters
//   TIMEOUT_CYCLES  memory wait cycles before a bus-error trap (0 = no watchdog)
//   CNT_W           width of the retired-instruction counter
//
// Ports
//   clk              in   core clock, rising edge
//   rst              in   synchronous, active-high reset
//   run_en           in   1 = execute, 0 = park in IDLE at the next boundary
//   mem_ready        in   memory accepted/completed the current request
//   dec_illegal      in   decoder flags an unknown opcode
//   dec_mem_enable   in   instruction accesses memory
//   dec_mem_rw_mode  in   0 = load, 1 = store
//   dec_r_w_src      in   register write source (RW_* codes)
//   dec_bra_mode     in   branch mode (BRA_* codes)
//   cmp_taken        in   branch comparator result
//   mem_req          out  memory request valid
//   mem_we           out  request is a write
//   mem_addr_sel     out  0 = PC (fetch), 1 = ALU result (data)
//   ir_load          out  latch memory read data into IR
//   rf_write         out  register file write enable
//   pc_write         out  PC update enable
//   pc_src           out  PC source (PC_SRC_* codes)
//   trap             out  sticky fault indication
//   instret          out  retired-instruction count, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_sequencer
   import rv_core_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_en,
   input  logic             mem_ready,
   input  logic             dec_illegal,
   input  logic             dec_mem_enable,
   input  logic             dec_mem_rw_mode,
   input  logic [1:0]       dec_r_w_src,
   input  logic [1:0]       dec_bra_mode,
   input  logic             cmp_taken,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_load,
   output logic             rf_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_instret;
   logic             w_retire;
   logic             w_wait;
   logic             w_clear;
   logic             w_timeout;

   // ---------------------------------------------------------------------------
   // Memory wait watchdog. The count restarts whenever the state changes, so
   // FETCH and MEM each get their own full wait budget.
   // ---------------------------------------------------------------------------
   assign w_clear = (w_state_next != r_state);

   mem_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_mem_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_clear),
      .i_wait    (w_wait),
      .o_timeout (w_timeout)
   );

   // ---------------------------------------------------------------------------
   // Output decode and next-state logic.
   // Memory request signals depend only on the state and the decode fields of
   // the held IR, so they stay stable until the mem_ready cycle. Architectural
   // writes (IR, RF, PC) are suppressed in a reset cycle so an abandoned
   // instruction leaves no trace.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output gets a default before the case so no path through
      // the block leaves a signal unassigned, which would infer a latch.
      w_state_next = r_state;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_load      = 1'b0;
      rf_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_PC4;
      trap         = 1'b0;
      w_retire     = 1'b0;
      w_wait       = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (run_en) w_state_next = ST_FETCH;
         end

         ST_FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ready && !rst;
            w_wait  = !mem_ready;
            // A ready arriving in the timeout cycle still completes the fetch.
            if (mem_ready)      w_state_next = ST_DECODE;
            else if (w_timeout) w_state_next = ST_TRAP;
         end

         ST_DECODE: begin
            w_state_next = dec_illegal ? ST_TRAP : ST_EXEC;
         end

         ST_EXEC: begin
            w_state_next = dec_mem_enable ? ST_MEM : ST_WB;
         end

         ST_MEM: begin
            mem_req      = 1'b1;
            mem_we       = dec_mem_rw_mode;
            mem_addr_sel = 1'b1;
            w_wait       = !mem_ready;
            if (mem_ready)      w_state_next = ST_WB;
            else if (w_timeout) w_state_next = ST_TRAP;
         end

         ST_WB: begin
            pc_write = !rst;
            // Stores have a register field in the encoding but never write it.
            rf_write = !rst && (dec_r_w_src != RW_NONE) &&
                       !(dec_mem_enable && dec_mem_rw_mode);
            pc_src   = pc_src_sel(dec_bra_mode, cmp_taken);
            w_retire = 1'b1;
            // run_en is only honoured here, at the instruction boundary.
            w_state_next = run_en ? ST_FETCH : ST_IDLE;
         end

         ST_TRAP: begin
            // Terminal until reset; run_en and mem_ready are ignored.
            trap = 1'b1;
         end

         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and retired-instruction counter.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_instret <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_retire) r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign instret = r_instret;

endmodule : multicycle_sequencer

// File: tb/tb_multicycle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed bench for multicycle_sequencer (TIMEOUT_CYCLES=8, CNT_W=4).
// Each instruction is described by its decode fields and the memory wait it
// sees; the bench expands that into the per-cycle output trace the sequencer
// must produce, and a negedge compare process checks every output against it.
// A few literal expectations pin the expansion itself.
// -----------------------------------------------------------------------------
module tb_multicycle_sequencer;
   import rv_core_pkg::*;

   localparam int unsigned TO = 8;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          run_en;
   logic          mem_ready;
   logic          dec_illegal;
   logic          dec_mem_enable;
   logic          dec_mem_rw_mode;
   logic [1:0]    dec_r_w_src;
   logic [1:0]    dec_bra_mode;
   logic          cmp_taken;
   logic          mem_req;
   logic          mem_we;
   logic          mem_addr_sel;
   logic          ir_load;
   logic          rf_write;
   logic          pc_write;
   logic [1:0]    pc_src;
   logic          trap;
   logic [CW-1:0] instret;

   multicycle_sequencer #(
      .TIMEOUT_CYCLES (TO),
      .CNT_W          (CW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .run_en          (run_en),
      .mem_ready       (mem_ready),
      .dec_illegal     (dec_illegal),
      .dec_mem_enable  (dec_mem_enable),
      .dec_mem_rw_mode (dec_mem_rw_mode),
      .dec_r_w_src     (dec_r_w_src),
      .dec_bra_mode    (dec_bra_mode),
      .cmp_taken       (cmp_taken),
      .mem_req         (mem_req),
      .mem_we          (mem_we),
      .mem_addr_sel    (mem_addr_sel),
      .ir_load         (ir_load),
      .rf_write        (rf_write),
      .pc_write        (pc_write),
      .pc_src          (pc_src),
      .trap            (trap),
      .instret         (instret)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       req;
      logic       we;
      logic       sel;
      logic       ir;
      logic       rf;
      logic       pcw;
      logic [1:0] src;
      logic       trp;
   } outs_t;

   localparam outs_t ZERO = '0;

   outs_t         exp_o = '0;
   logic [CW-1:0] exp_instret = '0;
   logic          chk_en = 1'b0;
   int            n_vec = 0;
   int            n_err = 0;

   // Observations used by the literal checks.
   logic [1:0]    last_wb_src = 2'b00;
   logic          last_wb_rf = 1'b0;
   int            cnt_data_req = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic outs_t mk(input logic req, input logic we, input logic sel,
                                input logic ir, input logic rf, input logic pcw,
                                input logic [1:0] src, input logic trp);
      outs_t o;
      o.req = req; o.we = we; o.sel = sel; o.ir = ir;
      o.rf  = rf;  o.pcw = pcw; o.src = src; o.trp = trp;
      return o;
   endfunction

   // Retirement rules, straight from the instruction semantics.
   function automatic logic model_rf(input logic [1:0] rsrc, input logic men, input logic rw);
      return (rsrc != 2'b00) && !(men && rw);
   endfunction

   function automatic logic [1:0] model_src(input logic [1:0] bra, input logic taken);
      case (bra)
         2'b01:   return 2'b01;
         2'b10:   return taken ? 2'b01 : 2'b00;
         2'b11:   return 2'b10;
         default: return 2'b00;
      endcase
   endfunction

   // Compare process: every output, every cycle the bench has an expectation.
   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_req",      32'(mem_req),      32'(exp_o.req));
         check("mem_we",       32'(mem_we),       32'(exp_o.we));
         check("mem_addr_sel", 32'(mem_addr_sel), 32'(exp_o.sel));
         check("ir_load",      32'(ir_load),      32'(exp_o.ir));
         check("rf_write",     32'(rf_write),     32'(exp_o.rf));
         check("pc_write",     32'(pc_write),     32'(exp_o.pcw));
         check("pc_src",       32'(pc_src),       32'(exp_o.src));
         check("trap",         32'(trap),         32'(exp_o.trp));
         check("instret",      32'(instret),      32'(exp_instret));
         if (exp_o.pcw) begin
            last_wb_src = pc_src;
            last_wb_rf  = rf_write;
         end
         if (mem_req && mem_addr_sel) cnt_data_req++;
      end
   end

   // One clock: publish this cycle's expectation, then advance past the edge.
   task automatic cycle(input outs_t e);
      exp_o = e;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      chk_en    = 1'b0;
      rst       = 1'b1;
      run_en    = 1'b0;
      mem_ready = 1'b0;
      exp_o     = ZERO;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst         = 1'b0;
      exp_instret = '0;
      chk_en      = 1'b1;
   endtask

   // IDLE cycle; mem_ready is held high to show it is ignored without a request.
   task automatic idle_cycle(input logic run);
      run_en    = run;
      mem_ready = 1'b1;
      cycle(ZERO);
      mem_ready = 1'b0;
   endtask

   task automatic trap_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         run_en    = i[0];
         mem_ready = ~i[0];
         cycle(mk(0, 0, 0, 0, 0, 0, 2'b00, 1));
      end
   endtask

   // One instruction from its FETCH cycle onward. fw/mw are the number of
   // mem_ready=0 cycles before ready in FETCH/MEM. run_after is applied from
   // EXEC on and decides whether WB continues to FETCH or parks in IDLE.
   task automatic run_instr(input logic ill, input logic men, input logic rw,
                            input logic [1:0] rsrc, input logic [1:0] bra,
                            input logic taken, input int fw, input int mw,
                            input logic run_after);
      dec_illegal     = ill;
      dec_mem_enable  = men;
      dec_mem_rw_mode = rw;
      dec_r_w_src     = rsrc;
      dec_bra_mode    = bra;
      cmp_taken       = taken;
      run_en          = 1'b1;
      for (int i = 0; i < fw; i++) begin
         mem_ready = 1'b0;
         cycle(mk(1, 0, 0, 0, 0, 0, 2'b00, 0));
      end
      mem_ready = 1'b1;
      cycle(mk(1, 0, 0, 1, 0, 0, 2'b00, 0));
      cycle(ZERO);                               // DECODE, ready ignored
      if (ill) begin
         mem_ready = 1'b0;
         return;
      end
      run_en = run_after;
      cycle(ZERO);                               // EXEC
      if (men) begin
         for (int i = 0; i < mw; i++) begin
            mem_ready = 1'b0;
            cycle(mk(1, rw, 1, 0, 0, 0, 2'b00, 0));
         end
         mem_ready = 1'b1;
         cycle(mk(1, rw, 1, 0, 0, 0, 2'b00, 0));
      end
      mem_ready = 1'b0;
      cycle(mk(0, 0, 0, 0, model_rf(rsrc, men, rw), 1, model_src(bra, taken), 0));
      exp_instret = exp_instret + CW'(1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_time_limit: bench did not reach its end");
      $fatal(1, "time limit");
   end

   initial begin
      int base;
      rst = 1'b1; run_en = 1'b0; mem_ready = 1'b0; dec_illegal = 1'b0;
      dec_mem_enable = 1'b0; dec_mem_rw_mode = 1'b0; dec_r_w_src = 2'b00;
      dec_bra_mode = 2'b00; cmp_taken = 1'b0;

      // Reset state.
      do_reset();
      check("reset_instret", 32'(instret), 32'd0);
      idle_cycle(1'b0);
      idle_cycle(1'b1);

      // 1. Three ADDs, zero wait, 4 cycles each.
      for (int i = 0; i < 3; i++)
         run_instr(0, 0, 0, RW_ALU, BRA_NONE, 0, 0, 0, 1);
      check("add_instret", 32'(instret), 32'd3);
      check("add_pc_src",  32'(last_wb_src), 32'd0);
      check("add_rf",      32'(last_wb_rf),  32'd1);

      // 2. LW with 3 wait cycles in MEM, then SW.
      base = cnt_data_req;
      run_instr(0, 1, 0, RW_MEM, BRA_NONE, 0, 1, 3, 1);
      check("lw_data_req_cycles", 32'(cnt_data_req - base), 32'd4);
      check("lw_rf", 32'(last_wb_rf), 32'd1);
      base = cnt_data_req;
      run_instr(0, 1, 1, RW_ALU, BRA_NONE, 0, 0, 2, 1);
      check("sw_data_req_cycles", 32'(cnt_data_req - base), 32'd3);
      check("sw_rf", 32'(last_wb_rf), 32'd0);

      // 3. Branches and jumps.
      run_instr(0, 0, 0, RW_NONE, BRA_CMP, 1, 0, 0, 1);
      check("beq_t_pc_src", 32'(last_wb_src), 32'd1);
      check("beq_t_rf",     32'(last_wb_rf),  32'd0);
      run_instr(0, 0, 0, RW_NONE, BRA_CMP, 0, 0, 0, 1);
      check("beq_nt_pc_src", 32'(last_wb_src), 32'd0);
      run_instr(0, 0, 0, RW_PC, BRA_JMP, 0, 0, 0, 1);
      check("jal_pc_src", 32'(last_wb_src), 32'd1);
      check("jal_rf",     32'(last_wb_rf),  32'd1);
      run_instr(0, 0, 0, RW_PC, BRA_ALU, 1, 0, 0, 1);
      check("jalr_pc_src", 32'(last_wb_src), 32'd2);

      // 5a. Reset during a MEM wait: request abandoned, counter cleared.
      dec_illegal = 1'b0; dec_mem_enable = 1'b1; dec_mem_rw_mode = 1'b0;
      dec_r_w_src = RW_MEM; dec_bra_mode = BRA_NONE; run_en = 1'b1;
      mem_ready = 1'b1;
      cycle(mk(1, 0, 0, 1, 0, 0, 2'b00, 0));     // FETCH
      mem_ready = 1'b0;
      cycle(ZERO);                               // DECODE
      cycle(ZERO);                               // EXEC
      cycle(mk(1, 0, 1, 0, 0, 0, 2'b00, 0));     // MEM wait
      cycle(mk(1, 0, 1, 0, 0, 0, 2'b00, 0));     // MEM wait
      rst = 1'b1; mem_ready = 1'b1; run_en = 1'b0;
      cycle(mk(1, 0, 1, 0, 0, 0, 2'b00, 0));     // reset cycle, still MEM
      rst = 1'b0;
      exp_instret = '0;
      check("rst_mem_instret", 32'(instret), 32'd0);
      idle_cycle(1'b0);

      // 5a'. Reset coinciding with a completing fetch: no IR load.
      idle_cycle(1'b1);
      rst = 1'b1; mem_ready = 1'b1;
      cycle(mk(1, 0, 0, 0, 0, 0, 2'b00, 0));
      rst = 1'b0;
      exp_instret = '0;
      idle_cycle(1'b0);

      // 5b. run_en dropped during EXEC: retires, then parks.
      idle_cycle(1'b1);
      run_instr(0, 0, 0, RW_ALU, BRA_NONE, 0, 0, 0, 0);
      idle_cycle(1'b0);
      idle_cycle(1'b0);
      check("park_instret", 32'(instret), 32'd1);

      // 4. Watchdog: ready arriving in the timeout cycle wins, in FETCH and MEM.
      idle_cycle(1'b1);
      run_instr(0, 0, 0, RW_ALU, BRA_NONE, 0, TO, 0, 1);
      run_instr(0, 1, 0, RW_MEM, BRA_NONE, 0, 0, TO, 1);
      check("late_ready_trap", 32'(trap), 32'd0);
      // No ready at all in FETCH: TO counted waits, the timeout cycle, then TRAP.
      for (int i = 0; i <= int'(TO); i++) begin
         mem_ready = 1'b0;
         cycle(mk(1, 0, 0, 0, 0, 0, 2'b00, 0));
      end
      trap_cycles(4);
      check("timeout_trap", 32'(trap), 32'd1);
      do_reset();

      // Illegal opcode traps out of DECODE.
      idle_cycle(1'b1);
      run_instr(1, 0, 0, RW_ALU, BRA_NONE, 0, 0, 0, 1);
      trap_cycles(3);
      check("illegal_trap", 32'(trap), 32'd1);
      do_reset();

      // 6. 16 retirements wrap the 4-bit counter to 0.
      idle_cycle(1'b1);
      for (int i = 0; i < 16; i++) begin
         run_instr(0, 0, 0, RW_ALU, BRA_NONE, 0, 0, 0, (i != 15));
         if (i == 14) check("pre_wrap_instret", 32'(instret), 32'd15);
      end
      check("wrap_instret", 32'(instret), 32'd0);
      idle_cycle(1'b0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_multicycle_sequencer
